// File: rtl/input_port_encoder.sv
// input_port_encoder
// Board-pin front end for the CPU input port. Each of the four slide switches
// and four push keys is synchronised (two flops) and debounced. The debounced
// switches drive port_in directly. Debounced key presses (released -> pressed)
// are collected in a pending set and handed out one at a time, lowest key
// index first, over a registered valid/ready handshake.
//
// Internal bit layout used throughout: bits [3:0] = sw, bits [7:4] = key_n.
// Keys stay active-low inside the design; only the event logic inverts them.

module input_port_encoder #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [3:0] sw,
    input  logic [3:0] key_n,
    input  logic       key_ready,
    output logic [3:0] port_in,
    output logic       key_valid,
    output logic [1:0] key_code
);

    localparam int              NBITS    = 8;
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Idle level of every bit: switches off (0), keys released (1).
    localparam logic [NBITS-1:0] IDLE_LEVEL = 8'hF0;

    logic [NBITS-1:0] raw;
    logic [NBITS-1:0] sync1_q;
    logic [NBITS-1:0] sync2_q;

    logic [NBITS-1:0] db_q;
    logic [NBITS-1:0] db_d;
    logic [CNT_W-1:0] cnt_q [NBITS];
    logic [CNT_W-1:0] cnt_d [NBITS];

    logic [3:0] press;
    logic [3:0] pend_q;
    logic [3:0] pend_d;
    logic       valid_q;
    logic       valid_d;
    logic [1:0] code_q;
    logic [1:0] code_d;
    logic [1:0] low_idx;

    assign raw = {key_n, sw};

    // Two-flop synchroniser for all eight asynchronous pins.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: count consecutive disagreeing cycles, accept the new
    // level once it has disagreed for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NBITS; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Debounced levels and their stability counters.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            db_q <= IDLE_LEVEL;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A press is a debounced key going from released (1) to pressed (0) on
    // this edge; it is visible in pend on the same edge the key level updates.
    assign press = db_q[7:4] & ~db_d[7:4];

    // Lowest-index pending key, the next one to be handed out.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = 2'(i);
            end
        end
    end

    // Output stage: reload whenever the slot is empty or being accepted.
    // The pending set is applied last so a new press beats a same-edge clear.
    always_comb begin
        pend_d  = pend_q;
        valid_d = valid_q;
        code_d  = code_q;
        if (!valid_q || key_ready) begin
            if (pend_q != 4'b0000) begin
                valid_d         = 1'b1;
                code_d          = low_idx;
                pend_d[low_idx] = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end
        pend_d = pend_d | press;
    end

    // Pending set and registered handshake outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pend_q  <= 4'b0000;
            valid_q <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    assign port_in   = db_q[3:0];
    assign key_valid = valid_q;
    assign key_code  = code_q;

endmodule

// File: tb/tb_input_port_encoder.sv
// Bench for input_port_encoder with DEBOUNCE_CYCLES = 4.
// A reference model runs alongside every clock: it delays the pins by two
// samples, keeps the last D synchronised samples and flips a debounced bit
// only when all of them disagree with it, and tracks pending presses as a set.

module tb_input_port_encoder;

    localparam int D = 4;

    logic       clk;
    logic       n_reset;
    logic [3:0] sw;
    logic [3:0] key_n;
    logic       key_ready;
    logic [3:0] port_in;
    logic       key_valid;
    logic [1:0] key_code;

    int n_tests = 0;
    int n_fail  = 0;

    input_port_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .sw        (sw),
        .key_n     (key_n),
        .key_ready (key_ready),
        .port_in   (port_in),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] m_s1, m_s2, m_db;
    logic [7:0] m_hist [$];
    logic [3:0] m_pend;
    logic       m_valid;
    logic [1:0] m_code;

    task automatic model_reset();
        m_s1 = 8'hF0;
        m_s2 = 8'hF0;
        m_db = 8'hF0;
        m_hist = {};
        for (int k = 0; k < D; k++) m_hist.push_back(8'hF0);
        m_pend  = 4'b0;
        m_valid = 1'b0;
        m_code  = 2'd0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [7:0] nd;
        logic [7:0] h;
        logic [3:0] np;
        bit         all_diff;
        m_hist.push_back(m_s2);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        nd = m_db;
        for (int b = 0; b < 8; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < m_hist.size(); k++) begin
                h = m_hist[k];
                if (h[b] == m_db[b]) all_diff = 1'b0;
            end
            if (all_diff) nd[b] = ~m_db[b];
        end
        np = m_pend;
        if (!m_valid || key_ready) begin
            if (np != 4'b0) begin
                for (int k = 3; k >= 0; k--) if (np[k]) m_code = 2'(k);
                m_valid = 1'b1;
                np[m_code] = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        np = np | (m_db[7:4] & ~nd[7:4]);
        m_pend = np;
        m_db   = nd;
        m_s2   = m_s1;
        m_s1   = {key_n, sw};
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got vld/code/port=%b/%0d/%b expected %b/%0d/%b",
                     name, act[6], act[5:4], act[3:0], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    function automatic logic [6:0] outs();
        return {key_valid, key_code, port_in};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model", outs(), {m_valid, m_code, m_db[3:0]});
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        #2;
        model_reset();
        check("reset_state", outs(), 7'd0);
        n_reset = 1'b1;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic [3:0] sw;
        logic [3:0] key_n;
        logic       rdy;
        logic [3:0] port;
        logic       vld;
        logic [1:0] code;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic [3:0] s, input logic [3:0] k, input logic r,
                       input logic [3:0] p, input logic v, input logic [1:0] c);
        vec_t e;
        e.sw = s; e.key_n = k; e.rdy = r; e.port = p; e.vld = v; e.code = c;
        tbl.push_back(e);
    endtask

    // Keys 1 and 3 pressed together with the consumer stalled, up to the
    // point where code 1 is presented and held.
    task automatic two_key_prefix(input string tag);
        int n;
        key_ready = 1'b0;
        key_n     = 4'b0101;
        n = 0;
        while (!key_valid && n < 20) begin
            tick();
            n++;
        end
        n_tests++;
        if (!key_valid) begin
            n_fail++;
            $display("FAIL %s_timeout: key_valid=%b after %0d cycles, required 1", tag, key_valid, n);
        end
        check({tag, "_first_code"}, outs(), {1'b1, 2'd1, 4'b0000});
        repeat (3) begin
            tick();
            check({tag, "_held"}, outs(), {1'b1, 2'd1, 4'b0000});
        end
    endtask

    int cnt_v;
    int hold;

    initial begin
        n_reset   = 1'b1;
        sw        = 4'b0000;
        key_n     = 4'b1111;
        key_ready = 1'b1;
        model_reset();
        #1;
        do_reset();

        // switch latency, glitch rejection, single key press / re-press / hold
        for (int i = 0; i < 6; i++) add(4'b1010, 4'hF, 1'b1, (i == 5) ? 4'b1010 : 4'b0000, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) add(4'b1011, 4'hF, 1'b1, 4'b1010, 1'b0, 2'd0);
        for (int i = 0; i < 6; i++) add(4'b1010, 4'hF, 1'b1, 4'b1010, 1'b0, 2'd0);
        for (int i = 0; i < 10; i++) add(4'b1010, 4'b1011, 1'b1, 4'b1010, i == 6, (i >= 6) ? 2'd2 : 2'd0);
        for (int i = 0; i < 7; i++) add(4'b1010, 4'hF, 1'b1, 4'b1010, 1'b0, 2'd2);
        for (int i = 0; i < 15; i++) add(4'b1010, 4'b1011, 1'b1, 4'b1010, i == 6, 2'd2);

        foreach (tbl[i]) begin
            sw        = tbl[i].sw;
            key_n     = tbl[i].key_n;
            key_ready = tbl[i].rdy;
            tick();
            check($sformatf("table_%0d", i), outs(), {tbl[i].vld, tbl[i].code, tbl[i].port});
        end

        // simultaneous presses, stalled consumer, then drained in order
        sw = 4'b0000;
        key_n = 4'hF;
        do_reset();
        two_key_prefix("multi");
        key_ready = 1'b1;
        tick();
        check("multi_second", outs(), {1'b1, 2'd3, 4'b0000});
        tick();
        check("multi_drained", outs(), {1'b0, 2'd3, 4'b0000});

        // merge: key 0 re-pressed twice while its first event is stalled
        key_n = 4'hF;
        do_reset();
        key_ready = 1'b0;
        key_n = 4'b1110;
        repeat (7) tick();
        check("merge_first", outs(), {1'b1, 2'd0, 4'b0000});
        repeat (2) begin
            key_n = 4'hF;
            repeat (7) tick();
            key_n = 4'b1110;
            repeat (7) tick();
        end
        key_ready = 1'b1;
        cnt_v = 0;
        repeat (10) begin
            tick();
            if (key_valid) cnt_v++;
        end
        n_tests++;
        if (cnt_v != 1) begin
            n_fail++;
            $display("FAIL merge_count: got %0d further events, required 1", cnt_v);
        end
        check("merge_empty", outs(), {1'b0, 2'd0, 4'b0000});

        // reset while an event is presented and another is pending
        key_n = 4'hF;
        do_reset();
        two_key_prefix("rstmid");
        #2;
        n_reset = 1'b0;
        #1;
        check("rstmid_async", outs(), 7'd0);
        model_reset();
        key_n = 4'hF;
        #1;
        n_reset = 1'b1;
        key_ready = 1'b1;
        cnt_v = 0;
        repeat (12) begin
            tick();
            if (key_valid) cnt_v++;
        end
        n_tests++;
        if (cnt_v != 0) begin
            n_fail++;
            $display("FAIL rstmid_stale: got %0d events after reset, required 0", cnt_v);
        end

        // switches high and key 0 held through reset release
        sw = 4'b1111;
        key_n = 4'b1110;
        do_reset();
        repeat (5) tick();
        check("thru_reset_early", outs(), {1'b0, 2'd0, 4'b0000});
        tick();
        check("thru_reset_port", outs(), {1'b0, 2'd0, 4'b1111});
        tick();
        check("thru_reset_key", outs(), {1'b1, 2'd0, 4'b1111});

        // randomized run against the model
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                sw    = sw ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
                key_n = key_n ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
                hold  = $urandom_range(1, 9);
            end
            hold--;
            key_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
